// File: rtl/life_pkg.sv
// life_pkg: board geometry, FSM state encoding and cell index type shared by the Life engine.
package life_pkg;
   localparam int BOARD_W = 8;
   localparam int BOARD_H = 8;
   localparam int SIZE = BOARD_W * BOARD_H;
   typedef logic [$clog2(SIZE)-1:0] cell_idx_t;
   typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
endpackage

// File: rtl/life_cell_rule.sv
// life_cell_rule: next state of one cell, with cells off the board edge counted dead.
module life_cell_rule #(
   parameter int WIDTH = 3,
   parameter int HEIGHT = 3
) (
   input  logic [(1<<(WIDTH+HEIGHT))-1:0] prev,
   input  logic [WIDTH+HEIGHT-1:0]        idx,
   output logic                           alive
);
   localparam int IW = WIDTH + HEIGHT;
   localparam logic [IW-1:0] C1 = IW'(1);
   localparam logic [IW-1:0] CW = IW'(1 << WIDTH);
   logic w_l, w_r, w_u, w_d;
   logic [7:0] w_nb;
   logic [3:0] w_cnt;
   assign w_l = idx[WIDTH-1:0] != '0;
   assign w_r = idx[WIDTH-1:0] != '1;
   assign w_u = idx[IW-1:WIDTH] != '0;
   assign w_d = idx[IW-1:WIDTH] != '1;
   // Index arithmetic may wrap; the edge masks zero any wrapped neighbour.
   assign w_nb = {w_u & w_l & prev[idx - CW - C1], w_u & prev[idx - CW], w_u & w_r & prev[idx - CW + C1],
                  w_l & prev[idx - C1], w_r & prev[idx + C1],
                  w_d & w_l & prev[idx + CW - C1], w_d & prev[idx + CW], w_d & w_r & prev[idx + CW + C1]};
   always_comb begin
      w_cnt = '0;
      for (int i = 0; i < 8; i++) w_cnt = w_cnt + {3'b0, w_nb[i]};
   end
   assign alive = (w_cnt == 4'd3) | (prev[idx] & (w_cnt == 4'd2));
endmodule

// File: rtl/life_step_engine.sv
// life_step_engine: advances the displayed board one generation every FRAMES_PER_GEN ticks,
// one cell per clock into a shadow buffer, committed atomically.
module life_step_engine
   import life_pkg::*;
#(
   parameter int WIDTH = $clog2(BOARD_W),
   parameter int HEIGHT = $clog2(BOARD_H),
   parameter int FRAMES_PER_GEN = 60,
   parameter logic [(1<<(WIDTH+HEIGHT))-1:0] INIT_PATTERN = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_tick,
   input  logic                           run,
   input  logic                           load,
   input  logic [(1<<(WIDTH+HEIGHT))-1:0] seed,
   output logic [(1<<(WIDTH+HEIGHT))-1:0] board,
   output logic                           busy,
   output logic                           gen_done,
   output logic [15:0]                    generation
);
   localparam int IW = WIDTH + HEIGHT;
   localparam int SZ = 1 << IW;
   localparam int FW = FRAMES_PER_GEN > 1 ? $clog2(FRAMES_PER_GEN) : 1;
   state_t r_state, w_state_nx;
   logic [FW-1:0] r_fcnt;
   logic [IW-1:0] r_idx;
   logic [SZ-1:0] r_prev, r_next, r_board, r_pseed;
   logic [15:0] r_gen;
   logic r_done, r_pend, w_cell, w_ld, w_last, w_go;

   life_cell_rule #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_rule (
      .prev(r_prev),
      .idx(r_idx),
      .alive(w_cell)
   );

   assign w_ld = load | r_pend;
   assign w_last = r_fcnt == FW'(FRAMES_PER_GEN - 1);
   assign w_go = frame_tick & run & w_last;

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE: w_state_nx = (!w_ld && w_go) ? SCAN : IDLE;
         SCAN: w_state_nx = (r_idx == IW'(SZ - 1)) ? COMMIT : SCAN;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_fcnt <= '0;
         r_idx <= '0;
         r_prev <= '0;
         r_next <= '0;
         r_board <= INIT_PATTERN;
         r_gen <= '0;
         r_done <= 1'b0;
         r_pend <= 1'b0;
         r_pseed <= '0;
      end else begin
         r_state <= w_state_nx;
         r_done <= r_state == COMMIT;
         if (r_state == IDLE) begin
            if (w_ld) begin
               r_board <= load ? seed : r_pseed;
               r_gen <= '0;
               r_fcnt <= '0;
               r_pend <= 1'b0;
            end else if (frame_tick && run) begin
               r_fcnt <= w_last ? '0 : r_fcnt + 1'b1;
               if (w_last) begin
                  r_prev <= r_board;
                  r_idx <= '0;
               end
            end
         end else if (load) begin
            // Held until the in-flight generation has committed.
            r_pend <= 1'b1;
            r_pseed <= seed;
         end
         if (r_state == SCAN) begin
            r_next[r_idx] <= w_cell;
            r_idx <= r_idx + 1'b1;
         end
         if (r_state == COMMIT) begin
            r_board <= r_next;
            r_gen <= r_gen + 1'b1;
         end
      end
   end

   assign board = r_board;
   assign busy = r_state != IDLE;
   assign gen_done = r_done;
   assign generation = r_gen;
endmodule

// File: tb/tb_life_step_engine.sv
// tb_life_step_engine: randomized run against a generation-level Life reference model.
module tb_life_step_engine;
   localparam int FPG = 3;
   localparam int SZ = 64;
   localparam logic [63:0] INIT = 64'h0000_1C00_0000_0070;
   logic clk = 1'b0;
   logic reset, frame_tick, run, load;
   logic [63:0] seed, board;
   logic busy, gen_done;
   logic [15:0] generation;
   int n_vec = 0;
   int n_bad = 0;
   logic [63:0] m_board, m_prev, m_pseed;
   logic [15:0] m_gen;
   int m_fcnt, m_left;
   logic m_pend, m_gd;

   life_step_engine #(.WIDTH(3), .HEIGHT(3), .FRAMES_PER_GEN(FPG), .INIT_PATTERN(INIT)) dut (
      .clk(clk),
      .reset(reset),
      .frame_tick(frame_tick),
      .run(run),
      .load(load),
      .seed(seed),
      .board(board),
      .busy(busy),
      .gen_done(gen_done),
      .generation(generation)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] life(input logic [63:0] b);
      logic [63:0] n;
      int cnt;
      n = '0;
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++)
               for (int dc = -1; dc <= 1; dc++)
                  if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                     cnt += int'(b[(r + dr) * 8 + c + dc]);
            n[r * 8 + c] = b[r * 8 + c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
         end
      return n;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         m_board = INIT;
         m_gen = '0;
         m_fcnt = 0;
         m_left = 0;
         m_pend = 1'b0;
         m_gd = 1'b0;
         m_prev = '0;
      end else begin
         m_gd = 1'b0;
         if (m_left != 0) begin
            if (load) begin
               m_pend = 1'b1;
               m_pseed = seed;
            end
            if (m_left == 1) begin
               m_board = life(m_prev);
               m_gen++;
               m_gd = 1'b1;
            end
            m_left--;
         end else if (load || m_pend) begin
            m_board = load ? seed : m_pseed;
            m_gen = '0;
            m_fcnt = 0;
            m_pend = 1'b0;
         end else if (frame_tick && run) begin
            if (m_fcnt == FPG - 1) begin
               m_fcnt = 0;
               m_prev = m_board;
               m_left = SZ + 1;
            end else m_fcnt++;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("board", board, m_board);
      check("busy", 64'(busy), 64'(m_left != 0));
      check("gen_done", 64'(gen_done), 64'(m_gd));
      check("generation", 64'(generation), 64'(m_gen));
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      frame_tick = 1'b0;
      run = 1'b1;
      load = 1'b0;
      seed = '0;
      step();
      check("reset_board", board, INIT);
      reset = 1'b0;
      load = 1'b1;
      seed = 64'h0000_0000_0000_0E00;
      step();
      load = 1'b0;
      check("blinker_load", board, 64'h0E00);
      repeat (3) tick();
      repeat (65) step();
      check("blinker_gen1", board, 64'h0004_0404);
      check("blinker_pulse", 64'(gen_done), 64'd1);
      check("blinker_count", 64'(generation), 64'd1);
      repeat (3) tick();
      repeat (65) step();
      check("blinker_gen2", board, 64'h0E00);
      check("blinker_count2", 64'(generation), 64'd2);
      for (int i = 0; i < 6000; i++) begin
         reset = $urandom_range(0, 1999) == 0;
         frame_tick = $urandom_range(0, 3) == 0;
         run = $urandom_range(0, 9) != 0;
         load = $urandom_range(0, 149) == 0;
         seed = {$urandom, $urandom} & ($urandom_range(0, 1) ? {$urandom, $urandom} : '1);
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
